stm_focus_assembler: RTL

Write-side front end of the focus STM memory path. It sits directly on `memory_bus_if` and filters CPU write transactions addressed to the STM BRAM select. It assembles each run of four consecutive 16-bit writes into one decoded focus entry (x, y, z, intensity, index, segment). Entries are buffered in a small FWFT FIFO and delivered over a valid/ready stream to the STM memory writer.

---
 rtl/stm_focus_assembler_if.sv | 64 ++++++
 rtl/stm_focus_assembler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/stm_focus_assembler_if.sv
// -----------------------------------------------------------------------------
// stm_focus_assembler_if
//
// Groups the CPU memory-bus write side and the focus-entry stream of the STM
// focus assembler into one bundle.
//
//   Bus side   : EN, WE, BRAM_SELECT, BRAM_ADDR, DATA_IN, PAGE, SEGMENT
//   Stream side: FOCUS_VALID/FOCUS_READY handshake plus decoded fields
//                FOCUS_X/Y/Z, FOCUS_INTENSITY, FOCUS_IDX, FOCUS_SEGMENT
//   Status     : FIFO_LEVEL, ERR_SEQ, OVERFLOW, ERR_CLR
//
// Handshake: an entry transfers on every rising clock edge where FOCUS_VALID
// and FOCUS_READY are both high. FOCUS_VALID never depends on FOCUS_READY,
// and while FOCUS_VALID is high and FOCUS_READY is low the presented fields
// hold steady until the transfer happens.
//
// Modports:
//   slave  - the assembler (consumes bus writes, produces the stream)
//   master - the environment (CPU bus driver and stream consumer)
// -----------------------------------------------------------------------------
interface stm_focus_assembler_if #(
   parameter int FIFO_DEPTH = 4
) ();
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   // CPU memory bus
   logic             EN;
   logic             WE;
   logic [1:0]       BRAM_SELECT;
   logic [13:0]      BRAM_ADDR;
   logic [15:0]      DATA_IN;
   logic [3:0]       PAGE;
   logic             SEGMENT;

   // focus entry stream
   logic             FOCUS_VALID;
   logic             FOCUS_READY;
   logic [17:0]      FOCUS_X;
   logic [17:0]      FOCUS_Y;
   logic [17:0]      FOCUS_Z;
   logic [7:0]       FOCUS_INTENSITY;
   logic [15:0]      FOCUS_IDX;
   logic             FOCUS_SEGMENT;

   // status / control
   logic [LVL_W-1:0] FIFO_LEVEL;
   logic             ERR_SEQ;
   logic             OVERFLOW;
   logic             ERR_CLR;

   modport slave (
      input  EN, WE, BRAM_SELECT, BRAM_ADDR, DATA_IN, PAGE, SEGMENT,
      input  FOCUS_READY, ERR_CLR,
      output FOCUS_VALID, FOCUS_X, FOCUS_Y, FOCUS_Z, FOCUS_INTENSITY,
      output FOCUS_IDX, FOCUS_SEGMENT, FIFO_LEVEL, ERR_SEQ, OVERFLOW
   );

   modport master (
      output EN, WE, BRAM_SELECT, BRAM_ADDR, DATA_IN, PAGE, SEGMENT,
      output FOCUS_READY, ERR_CLR,
      input  FOCUS_VALID, FOCUS_X, FOCUS_Y, FOCUS_Z, FOCUS_INTENSITY,
      input  FOCUS_IDX, FOCUS_SEGMENT, FIFO_LEVEL, ERR_SEQ, OVERFLOW
   );
endinterface

// File: rtl/stm_focus_assembler.sv
// -----------------------------------------------------------------------------
// stm_focus_assembler
//
// Write-side front end of the focus STM memory path. Watches CPU writes to the
// STM BRAM select, assembles each in-order run of four 16-bit words (same
// group, word positions 0..3) into one decoded focus entry and buffers the
// entries in a first-word-fall-through FIFO feeding a valid/ready stream.
//
// Ports:
//   CLK        bus clock, single domain
//   RST        synchronous active-high reset
//   bus        stm_focus_assembler_if.slave (bus writes in, focus stream out,
//              FIFO level and sticky ERR_SEQ / OVERFLOW flags)
//   state_dbg  current assembly FSM state (0..3 = next expected word)
// -----------------------------------------------------------------------------
module stm_focus_assembler #(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [1:0] SELECT_STM = 2'h3
) (
   input  logic                     CLK,
   input  logic                     RST,
   stm_focus_assembler_if.slave     bus,
   output logic [1:0]               state_dbg
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef struct packed {
      logic [17:0] x;
      logic [17:0] y;
      logic [17:0] z;
      logic [7:0]  intensity;
      logic [15:0] idx;
      logic        segment;
   } entry_t;

   // The state encoding equals the word position expected next.
   typedef enum logic [1:0] {
      EXP0 = 2'd0,
      EXP1 = 2'd1,
      EXP2 = 2'd2,
      EXP3 = 2'd3
   } state_t;

   // ---------------------------------------------------------------- state
   state_t           state_q, state_d;
   logic             hit_prev_q, hit_prev_d;
   logic [15:0]      w0_q, w0_d;
   logic [15:0]      w1_q, w1_d;
   logic [15:0]      w2_q, w2_d;
   logic [11:0]      group_q, group_d;
   logic [3:0]       page_q, page_d;
   logic             seg_q, seg_d;

   entry_t           mem_q [FIFO_DEPTH];
   entry_t           mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             err_q, err_d;
   logic             ovf_q, ovf_d;

   // ---------------------------------------------------------------- comb
   logic             hit;
   logic             cap;
   logic [1:0]       w_pos;
   logic [11:0]      grp;
   logic [1:0]       exp_w;
   logic             in_seq;
   logic             push;
   logic             err_set;
   entry_t           new_entry;
   entry_t           head;
   logic             valid;
   logic             full;
   logic             pop;
   logic             push_ok;
   logic             ovf_set;

   // Write strobe detection and the assembly FSM.
   always_comb begin
      hit        = bus.EN & bus.WE & (bus.BRAM_SELECT == SELECT_STM);
      // A bus write holds WE for several cycles; only its first cycle counts.
      cap        = hit & ~hit_prev_q;
      hit_prev_d = hit;

      w_pos  = bus.BRAM_ADDR[1:0];
      grp    = bus.BRAM_ADDR[13:2];
      exp_w  = state_q;
      // Word 0 opens a new group, so the group only has to match later words.
      in_seq = (w_pos == exp_w) && ((state_q == EXP0) || (grp == group_q));

      state_d = state_q;
      w0_d    = w0_q;
      w1_d    = w1_q;
      w2_d    = w2_q;
      group_d = group_q;
      page_d  = page_q;
      seg_d   = seg_q;
      push    = 1'b0;
      err_set = 1'b0;

      if (cap) begin
         if (in_seq) begin
            case (state_q)
               EXP0: begin
                  w0_d    = bus.DATA_IN;
                  group_d = grp;
                  page_d  = bus.PAGE;
                  seg_d   = bus.SEGMENT;
                  state_d = EXP1;
               end
               EXP1: begin
                  w1_d    = bus.DATA_IN;
                  state_d = EXP2;
               end
               EXP2: begin
                  w2_d    = bus.DATA_IN;
                  state_d = EXP3;
               end
               EXP3: begin
                  // Word 3 is taken straight from the bus into the entry.
                  push    = 1'b1;
                  state_d = EXP0;
               end
               default: state_d = EXP0;
            endcase
         end else begin
            // Out-of-order word: drop the partial entry. A stray word 0 is
            // still a valid start, so reuse it instead of waiting for another.
            err_set = 1'b1;
            if (w_pos == 2'd0) begin
               w0_d    = bus.DATA_IN;
               group_d = grp;
               page_d  = bus.PAGE;
               seg_d   = bus.SEGMENT;
               state_d = EXP1;
            end else begin
               state_d = EXP0;
            end
         end
      end
   end

   // Field decode: the 54 coordinate bits and the intensity byte are packed
   // back to back across the four words, LSB first.
   always_comb begin
      new_entry.x         = {w1_q[1:0], w0_q};
      new_entry.y         = {w2_q[3:0], w1_q[15:2]};
      new_entry.z         = {bus.DATA_IN[5:0], w2_q[15:4]};
      new_entry.intensity = bus.DATA_IN[13:6];
      new_entry.idx       = {page_q, group_q};
      new_entry.segment   = seg_q;
   end

   // Entry FIFO and sticky flags.
   always_comb begin
      head  = mem_q[rd_ptr_q];
      valid = (level_q != '0);
      full  = (level_q == LVL_W'(FIFO_DEPTH));
      pop   = valid & bus.FOCUS_READY;
      // A full FIFO can still take an entry when its head leaves this cycle.
      push_ok = push & (~full | pop);
      ovf_set = push & ~push_ok;

      mem_d = mem_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = new_entry;
      end

      wr_ptr_d = push_ok ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
      rd_ptr_d = pop     ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
      level_d  = level_q + LVL_W'(push_ok) - LVL_W'(pop);

      // A set in the same cycle as a clear wins.
      err_d = err_set | (err_q & ~bus.ERR_CLR);
      ovf_d = ovf_set | (ovf_q & ~bus.ERR_CLR);
   end

   // ---------------------------------------------------------------- regs
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= EXP0;
         hit_prev_q <= 1'b0;
         w0_q       <= '0;
         w1_q       <= '0;
         w2_q       <= '0;
         group_q    <= '0;
         page_q     <= '0;
         seg_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         err_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         hit_prev_q <= hit_prev_d;
         w0_q       <= w0_d;
         w1_q       <= w1_d;
         w2_q       <= w2_d;
         group_q    <= group_d;
         page_q     <= page_d;
         seg_q      <= seg_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         err_q      <= err_d;
         ovf_q      <= ovf_d;
      end
   end

   // Storage needs no reset: every slot is written before the level makes it
   // visible, and the outputs are masked while the FIFO is empty.
   always_ff @(posedge CLK) begin
      mem_q <= mem_d;
   end

   // ---------------------------------------------------------------- outputs
   assign bus.FOCUS_VALID     = valid;
   assign bus.FOCUS_X         = valid ? head.x         : '0;
   assign bus.FOCUS_Y         = valid ? head.y         : '0;
   assign bus.FOCUS_Z         = valid ? head.z         : '0;
   assign bus.FOCUS_INTENSITY = valid ? head.intensity : '0;
   assign bus.FOCUS_IDX       = valid ? head.idx       : '0;
   assign bus.FOCUS_SEGMENT   = valid ? head.segment   : 1'b0;
   assign bus.FIFO_LEVEL      = level_q;
   assign bus.ERR_SEQ         = err_q;
   assign bus.OVERFLOW        = ovf_q;
   assign state_dbg           = state_q;

endmodule
